// File: rtl/bitfusion_sequencer.sv
// Tile sequencer for an ARRAY_SIZE x ARRAY_SIZE bitfusion array: buffer load, optional
// accumulator clear, skewed compute wavefront and drain, one tile per accepted start.
module bitfusion_sequencer #(
    parameter int unsigned ARRAY_SIZE = 2,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MAX_BEATS  = 8,
    parameter int unsigned DRAIN_CYC  = 2
) (
    input  logic                                 clk,
    input  logic                                 RST,
    input  logic                                 start,
    input  logic [$clog2(MAX_BEATS+1)-1:0]       cfg_beats,
    input  logic                                 cfg_bcast,
    input  logic                                 cfg_reuse_w,
    input  logic                                 cfg_clear,
    input  logic [2:0]                           cfg_input_bitwidth,
    input  logic [2:0]                           cfg_weight_bitwidth,
    input  logic [DATA_W-1:0]                    in_data,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    output logic [DATA_W-1:0]                    data_in,
    output logic [ARRAY_SIZE-1:0]                IBUF_wr_en,
    output logic [ARRAY_SIZE*ARRAY_SIZE-1:0]     WBUF_wr_en,
    output logic [ARRAY_SIZE-1:0]                input_rd_en,
    output logic [ARRAY_SIZE*ARRAY_SIZE-1:0]     weight_rd_en,
    output logic [ARRAY_SIZE-1:0]                acc_clear,
    output logic [2:0]                           input_bitwidth,
    output logic [2:0]                           weight_bitwidth,
    output logic                                 busy,
    output logic                                 done
);

    localparam int unsigned BeatW     = $clog2(MAX_BEATS + 1);
    localparam int unsigned NumFu     = ARRAY_SIZE * ARRAY_SIZE;
    localparam int unsigned MaxT      = 2 * (ARRAY_SIZE - 1) + MAX_BEATS;
    localparam int unsigned CntMax0   = (NumFu > MaxT) ? NumFu : MaxT;
    localparam int unsigned CntMax    = (CntMax0 > DRAIN_CYC) ? CntMax0 : DRAIN_CYC;
    localparam int unsigned CntW      = $clog2(CntMax + 1);
    localparam int unsigned DrainLast = (DRAIN_CYC == 0) ? 0 : DRAIN_CYC - 1;

    typedef enum logic [2:0] {
        StIdle,
        StLoadI,
        StLoadW,
        StClear,
        StCompute,
        StDrain,
        StDone
    } state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [BeatW-1:0]       beats_q, beats_d, beats_eff;
    logic                   bcast_q, bcast_d;
    logic                   reuse_q, reuse_d;
    logic                   clear_q, clear_d;
    logic [2:0]             ibw_q, ibw_d;
    logic [2:0]             wbw_q, wbw_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic [ARRAY_SIZE-1:0]  ibuf_wr_q, ibuf_wr_d;
    logic [NumFu-1:0]       wbuf_wr_q, wbuf_wr_d;
    logic [ARRAY_SIZE-1:0]  in_rd_q, in_rd_d;
    logic [NumFu-1:0]       wt_rd_q, wt_rd_d;
    logic [ARRAY_SIZE-1:0]  acc_clr_q, acc_clr_d;
    logic                   xfer;
    int unsigned            cnt_now, t_nxt, tile_last;

    assign in_ready = (state_q == StLoadI) || (state_q == StLoadW);
    assign xfer     = in_valid && in_ready;

    // Zero beats still runs one beat; oversize requests clamp to what the buffers hold.
    always_comb begin
        beats_eff = cfg_beats;
        if (cfg_beats == '0) begin
            beats_eff = BeatW'(1);
        end else if (32'(cfg_beats) > MAX_BEATS) begin
            beats_eff = BeatW'(MAX_BEATS);
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        beats_d   = beats_q;
        bcast_d   = bcast_q;
        reuse_d   = reuse_q;
        clear_d   = clear_q;
        ibw_d     = ibw_q;
        wbw_d     = wbw_q;
        data_d    = data_q;
        ibuf_wr_d = '0;
        wbuf_wr_d = '0;
        cnt_now   = 32'(cnt_q);
        tile_last = 2 * (ARRAY_SIZE - 1) + 32'(beats_q) - 1;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    beats_d = beats_eff;
                    bcast_d = cfg_bcast;
                    reuse_d = cfg_reuse_w;
                    clear_d = cfg_clear;
                    ibw_d   = cfg_input_bitwidth;
                    wbw_d   = cfg_weight_bitwidth;
                    cnt_d   = '0;
                    state_d = StLoadI;
                end
            end
            StLoadI: begin
                if (xfer) begin
                    data_d = in_data;
                    for (int unsigned i = 0; i < ARRAY_SIZE; i++) begin
                        ibuf_wr_d[i] = bcast_q || (cnt_now == i);
                    end
                    if (bcast_q || (cnt_now == ARRAY_SIZE - 1)) begin
                        cnt_d = '0;
                        if (!reuse_q) begin
                            state_d = StLoadW;
                        end else if (clear_q) begin
                            state_d = StClear;
                        end else begin
                            state_d = StCompute;
                        end
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StLoadW: begin
                if (xfer) begin
                    data_d = in_data;
                    for (int unsigned i = 0; i < NumFu; i++) begin
                        wbuf_wr_d[i] = bcast_q || (cnt_now == i);
                    end
                    if (bcast_q || (cnt_now == NumFu - 1)) begin
                        cnt_d   = '0;
                        state_d = clear_q ? StClear : StCompute;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StClear: begin
                cnt_d   = '0;
                state_d = StCompute;
            end
            StCompute: begin
                if (cnt_now == tile_last) begin
                    cnt_d   = '0;
                    state_d = (DRAIN_CYC == 0) ? StDone : StDrain;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDrain: begin
                if (cnt_now == DrainLast) begin
                    cnt_d   = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Read enables are decoded from the next state/count so the registered copies line up
    // with the COMPUTE cycle they belong to.
    always_comb begin
        t_nxt     = 32'(cnt_d);
        in_rd_d   = '0;
        wt_rd_d   = '0;
        acc_clr_d = '0;
        if (state_d == StCompute) begin
            for (int unsigned r = 0; r < ARRAY_SIZE; r++) begin
                in_rd_d[r] = (t_nxt >= r) && (t_nxt < r + 32'(beats_q));
                for (int unsigned c = 0; c < ARRAY_SIZE; c++) begin
                    wt_rd_d[r*ARRAY_SIZE+c] = (t_nxt >= r + c) &&
                                              (t_nxt < r + c + 32'(beats_q));
                end
            end
        end
        if (state_d == StClear) begin
            acc_clr_d = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            beats_q   <= '0;
            bcast_q   <= 1'b0;
            reuse_q   <= 1'b0;
            clear_q   <= 1'b0;
            ibw_q     <= '0;
            wbw_q     <= '0;
            data_q    <= '0;
            ibuf_wr_q <= '0;
            wbuf_wr_q <= '0;
            in_rd_q   <= '0;
            wt_rd_q   <= '0;
            acc_clr_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            beats_q   <= beats_d;
            bcast_q   <= bcast_d;
            reuse_q   <= reuse_d;
            clear_q   <= clear_d;
            ibw_q     <= ibw_d;
            wbw_q     <= wbw_d;
            data_q    <= data_d;
            ibuf_wr_q <= ibuf_wr_d;
            wbuf_wr_q <= wbuf_wr_d;
            in_rd_q   <= in_rd_d;
            wt_rd_q   <= wt_rd_d;
            acc_clr_q <= acc_clr_d;
        end
    end

    assign data_in         = data_q;
    assign IBUF_wr_en      = ibuf_wr_q;
    assign WBUF_wr_en      = wbuf_wr_q;
    assign input_rd_en     = in_rd_q;
    assign weight_rd_en    = wt_rd_q;
    assign acc_clear       = acc_clr_q;
    assign input_bitwidth  = ibw_q;
    assign weight_bitwidth = wbw_q;
    assign busy            = (state_q != StIdle);
    assign done            = (state_q == StDone);

    a_done_pulse: assert property (@(posedge clk) disable iff (RST) done |=> !done);
    a_rd_in_compute: assert property (@(posedge clk) disable iff (RST)
        (state_q != StCompute) |-> ((input_rd_en == '0) && (weight_rd_en == '0)));

endmodule
